// File: rtl/one_to_eight_demux_pkg.sv
// rtl/one_to_eight_demux_pkg.sv - shared constants and slot state type for the 1:8 demux
package one_to_eight_demux_pkg;

    localparam int NUM_CH     = 8;
    localparam int SEL_W      = 3;
    localparam int CNT_W      = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/one_to_eight_demux_channel_slot.sv
// rtl/one_to_eight_demux_channel_slot.sv - one-deep holding register with valid flag per channel
module demux_channel_slot
    import one_to_eight_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_t       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // load is only raised by the top when the slot is empty or popping this cycle
    always_comb begin
        pop     = (state_q == SLOT_FULL) && out_ready;
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            data_d = load_data;
        end
        case (state_q)
            SLOT_EMPTY: state_d = load ? SLOT_FULL : SLOT_EMPTY;
            SLOT_FULL:  state_d = (pop && !load) ? SLOT_EMPTY : SLOT_FULL;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SLOT_FULL);
        out_data  = data_q;
    end

endmodule

// File: rtl/one_to_eight_demux.sv
// rtl/one_to_eight_demux.sv - routes one input byte stream to eight buffered output lanes
module one_to_eight_demux
    import one_to_eight_demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [CNT_W-1:0]         accept_cnt,
    output logic                     busy
);

    logic              accept;
    logic [NUM_CH-1:0] load_vec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // target may take a byte if empty or being drained in the same cycle
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign load_vec[k] = accept && (in_sel == SEL_W'(k));

        demux_channel_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_vec[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign accept_cnt = cnt_q;
    assign busy       = |out_valid;

endmodule

// File: tb/tb_one_to_eight_demux.sv
// tb/tb_one_to_eight_demux.sv - directed self-checking bench for one_to_eight_demux
module tb_one_to_eight_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [15:0] accept_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    one_to_eight_demux #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .accept_cnt (accept_cnt),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lane(input int k);
        return out_data[k*8 +: 8];
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_sel    = 3'd0;
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'h00);
        chk("reset_out_data", out_data, 64'h0);
        chk("reset_accept_cnt", 64'(accept_cnt), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // fan-out: 0x11*(k+1) to each lane, no consumer
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_sel   = 3'(k);
            in_data  = 8'(8'h11 * (k + 1));
            #1;
            chk("fanout_in_ready", 64'(in_ready), 64'h1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("fanout_out_valid", 64'(out_valid), 64'hFF);
        chk("fanout_out_data", out_data, 64'h8877665544332211);
        chk("fanout_accept_cnt", 64'(accept_cnt), 64'd8);
        chk("fanout_busy", 64'(busy), 64'h1);

        // back-pressure on full lane 3
        in_valid = 1'b1;
        in_sel   = 3'd3;
        in_data  = 8'hAB;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("bp_in_ready_low", 64'(in_ready), 64'h0);
            chk("bp_lane3_hold", 64'(lane(3)), 64'h44);
            tick();
        end
        out_ready = 8'h08;
        #1;
        chk("bp_in_ready_release", 64'(in_ready), 64'h1);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        chk("bp_lane3_new", 64'(lane(3)), 64'hAB);
        chk("bp_out_valid", 64'(out_valid), 64'hFF);
        chk("bp_accept_cnt", 64'(accept_cnt), 64'd9);

        // drain lane 1, then accept on 1 while popping 0 and 6
        out_ready = 8'h02;
        tick();
        chk("drain1_out_valid", 64'(out_valid), 64'hFD);
        out_ready = 8'h41;
        in_valid  = 1'b1;
        in_sel    = 3'd1;
        in_data   = 8'hC1;
        tick();
        in_valid  = 1'b0;
        out_ready = 8'h00;
        #1;
        chk("conc_out_valid", 64'(out_valid), 64'hBE);
        chk("conc_lane1", 64'(lane(1)), 64'hC1);
        chk("conc_accept_cnt", 64'(accept_cnt), 64'd10);

        // full-throughput stream into lane 4 while it drains
        out_ready = 8'h10;
        in_valid  = 1'b1;
        in_sel    = 3'd4;
        for (int i = 1; i <= 32; i++) begin
            in_data = 8'(i);
            #1;
            chk("thr_in_ready", 64'(in_ready), 64'h1);
            tick();
            chk("thr_lane4", 64'(lane(4)), 64'(i));
            chk("thr_valid4", 64'(out_valid[4]), 64'h1);
        end
        in_valid = 1'b0;
        tick();
        chk("thr_drain_out_valid", 64'(out_valid), 64'hAE);
        chk("thr_accept_cnt", 64'(accept_cnt), 64'd42);

        // ready on empty lanes has no effect
        out_ready = 8'h51;
        tick();
        out_ready = 8'h00;
        chk("idle_ready_out_valid", 64'(out_valid), 64'hAE);
        chk("idle_ready_lane4", 64'(lane(4)), 64'h20);

        // asynchronous reset mid-stream with lanes 2 and 5 full
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        in_data   = 8'h5A;
        out_ready = 8'hFF;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", 64'(out_valid), 64'h00);
        chk("mid_reset_out_data", out_data, 64'h0);
        chk("mid_reset_accept_cnt", 64'(accept_cnt), 64'h0);
        chk("mid_reset_busy", 64'(busy), 64'h0);
        tick();
        chk("held_reset_out_valid", 64'(out_valid), 64'h00);
        chk("held_reset_accept_cnt", 64'(accept_cnt), 64'h0);
        in_valid  = 1'b0;
        out_ready = 8'h00;
        rst_n     = 1'b1;
        in_sel    = 3'd7;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'h1);

        // counter wrap after 65535 + 1 accepts
        out_ready = 8'h01;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        in_data   = 8'h77;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("wrap_cnt_max", 64'(accept_cnt), 64'hFFFF);
        tick();
        chk("wrap_cnt_zero", 64'(accept_cnt), 64'h0);
        chk("wrap_valid0", 64'(out_valid), 64'h01);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
